// File: rtl/exec_stage_mc.sv
`default_nettype none
// ============================================================================
//  Module   : exec_stage_mc
//  Brief    : Execute stage with forwarding, branch resolve, valid/ready
//             handshake, EX/MEM output register and iterative MUL/DIVU/REMU.
//  Revision : 1.0 - initial release
// ============================================================================
module exec_stage_mc #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            exe_cmd,
    input  logic [DATA_W-1:0]     val1,
    input  logic [DATA_W-1:0]     val2,
    input  logic [DATA_W-1:0]     val_src2,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [1:0]            br_type,
    input  logic                  wb_en,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic [DATA_W-1:0]     fwd_mem,
    input  logic [DATA_W-1:0]     fwd_wb,
    input  logic [1:0]            val1_sel,
    input  logic [1:0]            val2_sel,
    input  logic [1:0]            st_sel,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_alu,
    output logic [DATA_W-1:0]     out_st_val,
    output logic [DATA_W-1:0]     out_pc,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic                  out_wb_en,
    output logic                  out_mem_write,
    output logic                  out_mem_read,
    output logic                  br_taken,
    output logic [DATA_W-1:0]     br_addr,
    output logic                  busy
);

    localparam int c_sh_w = $clog2(DATA_W);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_iter = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [3:0] c_op_mul  = 4'd11;
    localparam logic [3:0] c_op_divu = 4'd12;
    localparam logic [3:0] c_op_remu = 4'd13;

    localparam logic [c_sh_w-1:0] c_cnt_last = c_sh_w'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] fwd_pick(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] own,
        input logic [DATA_W-1:0] m,
        input logic [DATA_W-1:0] w
    );
        case (sel)
            2'b01:   fwd_pick = m;
            2'b10:   fwd_pick = w;
            default: fwd_pick = own;
        endcase
    endfunction

    logic [1:0]          r_state;
    logic [c_sh_w-1:0]   r_cnt;
    logic [3:0]          r_cmd;
    logic [DATA_W-1:0]   r_opa, r_opb, r_acc;
    logic [DATA_W-1:0]   r_st, r_pc;
    logic [REG_ADDR_W-1:0] r_dest;
    logic                r_wb_en, r_mem_write, r_mem_read;

    logic [DATA_W-1:0]   w_a, w_b, w_st, w_alu;
    logic [DATA_W-1:0]   w_acc_n, w_opa_n, w_opb_n, w_iter_res;
    logic [DATA_W:0]     w_rem_shift, w_diff;
    logic                w_ge, w_is_iter, w_out_free, w_accept, w_last;
    logic                w_single_load, w_iter_load;

    assign w_a  = fwd_pick(val1_sel, val1, fwd_mem, fwd_wb);
    assign w_b  = fwd_pick(val2_sel, val2, fwd_mem, fwd_wb);
    assign w_st = fwd_pick(st_sel, val_src2, fwd_mem, fwd_wb);

    always_comb begin
        w_alu = '0;
        case (exe_cmd)
            4'd0:    w_alu = w_b;
            4'd1:    w_alu = ~w_b;
            4'd2:    w_alu = w_a + w_b;
            4'd3:    w_alu = w_a - w_b;
            4'd4:    w_alu = w_a & w_b;
            4'd5:    w_alu = w_a | w_b;
            4'd6:    w_alu = ~(w_a | w_b);
            4'd7:    w_alu = w_a ^ w_b;
            4'd8:    w_alu = w_a << w_b[c_sh_w-1:0];
            4'd9:    w_alu = $signed(w_a) >>> w_b[c_sh_w-1:0];
            4'd10:   w_alu = w_a >> w_b[c_sh_w-1:0];
            default: w_alu = '0;
        endcase
    end

    assign w_is_iter  = (exe_cmd == c_op_mul) | (exe_cmd == c_op_divu) | (exe_cmd == c_op_remu);
    assign w_out_free = ~out_valid | out_ready;
    assign in_ready   = (r_state == c_st_idle) & w_out_free & ~flush;
    assign w_accept   = in_valid & in_ready;
    assign busy       = (r_state != c_st_idle);

    // MUL keeps multiplicand in opa, multiplier in opb; divide keeps divisor in
    // opa and the dividend shifting out of opb while quotient bits shift in.
    assign w_rem_shift = {r_acc, r_opb[DATA_W-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_opa};
    assign w_ge        = ~w_diff[DATA_W];

    always_comb begin
        if (r_cmd == c_op_mul) begin
            w_acc_n = r_acc + (r_opb[0] ? r_opa : '0);
            w_opa_n = r_opa << 1;
            w_opb_n = r_opb >> 1;
        end else begin
            w_acc_n = w_ge ? w_diff[DATA_W-1:0] : w_rem_shift[DATA_W-1:0];
            w_opa_n = r_opa;
            w_opb_n = {r_opb[DATA_W-2:0], w_ge};
        end
    end

    assign w_last = (r_state == c_st_iter) & (r_cnt == c_cnt_last);

    // The last step's result goes straight to the output when it is free, so
    // DONE is only occupied while the MEM stage applies backpressure.
    always_comb begin
        if (r_state == c_st_iter)
            w_iter_res = (r_cmd == c_op_divu) ? w_opb_n : w_acc_n;
        else
            w_iter_res = (r_cmd == c_op_divu) ? r_opb : r_acc;
    end

    assign w_single_load = w_accept & ~w_is_iter;
    assign w_iter_load   = (w_last | (r_state == c_st_done)) & w_out_free & ~flush;

    always_comb begin
        case (br_type)
            2'b01:   br_taken = (w_a == w_st) & w_accept;
            2'b10:   br_taken = (w_a != w_st) & w_accept;
            2'b11:   br_taken = w_accept;
            default: br_taken = 1'b0;
        endcase
    end

    assign br_addr = pc_in + val2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_cmd       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_acc       <= '0;
            r_st        <= '0;
            r_pc        <= '0;
            r_dest      <= '0;
            r_wb_en     <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (flush) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: if (w_accept & w_is_iter) begin
                    r_state     <= c_st_iter;
                    r_cnt       <= '0;
                    r_cmd       <= exe_cmd;
                    r_opa       <= (exe_cmd == c_op_mul) ? w_a : w_b;
                    r_opb       <= (exe_cmd == c_op_mul) ? w_b : w_a;
                    r_acc       <= '0;
                    r_st        <= w_st;
                    r_pc        <= pc_in;
                    r_dest      <= dest;
                    r_wb_en     <= wb_en;
                    r_mem_write <= mem_write;
                    r_mem_read  <= mem_read;
                end
                c_st_iter: begin
                    r_opa <= w_opa_n;
                    r_opb <= w_opb_n;
                    r_acc <= w_acc_n;
                    r_cnt <= r_cnt + c_sh_w'(1);
                    if (w_last)
                        r_state <= w_out_free ? c_st_idle : c_st_done;
                end
                c_st_done: if (w_out_free) r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_alu       <= '0;
            out_st_val    <= '0;
            out_pc        <= '0;
            out_dest      <= '0;
            out_wb_en     <= 1'b0;
            out_mem_write <= 1'b0;
            out_mem_read  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_single_load) begin
            out_valid     <= 1'b1;
            out_alu       <= w_alu;
            out_st_val    <= w_st;
            out_pc        <= pc_in;
            out_dest      <= dest;
            out_wb_en     <= wb_en;
            out_mem_write <= mem_write;
            out_mem_read  <= mem_read;
        end else if (w_iter_load) begin
            out_valid     <= 1'b1;
            out_alu       <= w_iter_res;
            out_st_val    <= r_st;
            out_pc        <= r_pc;
            out_dest      <= r_dest;
            out_wb_en     <= r_wb_en;
            out_mem_write <= r_mem_write;
            out_mem_read  <= r_mem_read;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_stage_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exec_stage_mc
//  Brief    : Directed and randomized bench for exec_stage_mc.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exec_stage_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [3:0]  exe_cmd = '0;
    logic [31:0] val1 = '0, val2 = '0, val_src2 = '0, pc_in = '0;
    logic [1:0]  br_type = '0;
    logic        wb_en = 1'b0, mem_write = 1'b0, mem_read = 1'b0;
    logic [4:0]  dest = '0;
    logic [31:0] fwd_mem = '0, fwd_wb = '0;
    logic [1:0]  val1_sel = '0, val2_sel = '0, st_sel = '0;
    logic        flush = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_alu, out_st_val, out_pc, br_addr;
    logic [4:0]  out_dest;
    logic        out_wb_en, out_mem_write, out_mem_read, br_taken, busy;

    int checks = 0;
    int failures = 0;

    exec_stage_mc #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exe_cmd(exe_cmd), .val1(val1), .val2(val2), .val_src2(val_src2),
        .pc_in(pc_in), .br_type(br_type), .wb_en(wb_en), .mem_write(mem_write),
        .mem_read(mem_read), .dest(dest), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
        .val1_sel(val1_sel), .val2_sel(val2_sel), .st_sel(st_sel), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu(out_alu),
        .out_st_val(out_st_val), .out_pc(out_pc), .out_dest(out_dest),
        .out_wb_en(out_wb_en), .out_mem_write(out_mem_write),
        .out_mem_read(out_mem_read), .br_taken(br_taken), .br_addr(br_addr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] own);
        if (sel == 2'b01)      return fwd_mem;
        else if (sel == 2'b10) return fwd_wb;
        else                   return own;
    endfunction

    // Behavioural reference for every opcode.
    function automatic logic [31:0] ref_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (cmd)
            4'd0:  return b;
            4'd1:  return ~b;
            4'd2:  return a + b;
            4'd3:  return a - b;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return ~(a | b);
            4'd7:  return a ^ b;
            4'd8:  return a << sh;
            4'd9:  return $signed(a) >>> sh;
            4'd10: return a >> sh;
            4'd11: return a * b;
            4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_br(input logic [1:0] bt, input logic [31:0] a, input logic [31:0] st);
        case (bt)
            2'b01:   return a == st;
            2'b10:   return a != st;
            2'b11:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic randomize_inputs();
        val1 = $urandom; val2 = $urandom; val_src2 = $urandom; pc_in = $urandom;
        fwd_mem = $urandom; fwd_wb = $urandom;
        val1_sel = 2'($urandom_range(0, 3)); val2_sel = 2'($urandom_range(0, 3));
        st_sel = 2'($urandom_range(0, 3)); br_type = 2'($urandom_range(0, 3));
        wb_en = 1'($urandom); mem_write = 1'($urandom); mem_read = 1'($urandom);
        dest = 5'($urandom);
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        tick();
    endtask

    task automatic run_iter(input string tag);
        logic [31:0] e_res, e_st, e_pc;
        logic [4:0]  e_dest;
        logic [2:0]  e_ctl;
        int lat;
        e_res  = ref_op(exe_cmd, pick(val1_sel, val1), pick(val2_sel, val2));
        e_st   = pick(st_sel, val_src2);
        e_pc   = pc_in;
        e_dest = dest;
        e_ctl  = {wb_en, mem_write, mem_read};
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        randomize_inputs();
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            check({tag, ".stall"}, 32'(in_ready), 32'd0);
            check({tag, ".busy"}, 32'(busy), 32'd1);
            tick();
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd33);
        check({tag, ".alu"}, out_alu, e_res);
        check({tag, ".st"}, out_st_val, e_st);
        check({tag, ".pc"}, out_pc, e_pc);
        check({tag, ".dest"}, 32'(out_dest), 32'(e_dest));
        check({tag, ".ctl"}, 32'({out_wb_en, out_mem_write, out_mem_read}), 32'(e_ctl));
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] e_alu, e_st, e_a;
        logic [3:0]  c;

        // Reset state
        tick(); tick();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_alu", out_alu, 32'd0);
        check("rst.out_pc", out_pc, 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        #2 rst = 1'b0;
        tick();

        // ADD with operand 2 from EX/MEM forwarding
        exe_cmd = 4'd2; val1 = 32'd5; val2_sel = 2'b01; fwd_mem = 32'd7;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("add.out_valid", 32'(out_valid), 32'd1);
        check("add.out_alu", out_alu, 32'd12);

        // Randomized back-to-back single-cycle ops
        for (int i = 0; i < 40; i++) begin
            randomize_inputs();
            c = 4'($urandom_range(0, 12));
            if (c > 4'd10) c = c + 4'd3;
            exe_cmd = c;
            in_valid = 1'b1; out_ready = 1'b1;
            e_a   = pick(val1_sel, val1);
            e_st  = pick(st_sel, val_src2);
            e_alu = ref_op(c, e_a, pick(val2_sel, val2));
            #1;
            check("single.in_ready", 32'(in_ready), 32'd1);
            check("single.br_taken", 32'(br_taken), 32'(ref_br(br_type, e_a, e_st)));
            check("single.br_addr", br_addr, pc_in + val2);
            tick();
            check("single.out_valid", 32'(out_valid), 32'd1);
            check("single.alu", out_alu, e_alu);
            check("single.st", out_st_val, e_st);
            check("single.pc", out_pc, pc_in);
            check("single.dest", 32'(out_dest), 32'(dest));
            check("single.ctl", 32'({out_wb_en, out_mem_write, out_mem_read}), 32'({wb_en, mem_write, mem_read}));
        end
        drain();

        // Directed iterative ops
        val1_sel = 2'b00; val2_sel = 2'b00; st_sel = 2'b00;
        exe_cmd = 4'd11; val1 = 32'd7;   val2 = 32'd6; run_iter("mul7x6");
        val1_sel = 2'b00; val2_sel = 2'b00; st_sel = 2'b00;
        exe_cmd = 4'd12; val1 = 32'd100; val2 = 32'd7; run_iter("divu100_7");
        val1_sel = 2'b00; val2_sel = 2'b00; st_sel = 2'b00;
        exe_cmd = 4'd13; val1 = 32'd100; val2 = 32'd7; run_iter("remu100_7");
        val1_sel = 2'b00; val2_sel = 2'b00; st_sel = 2'b00;
        exe_cmd = 4'd12; val1 = 32'd9;   val2 = 32'd0; run_iter("divu9_0");
        val1_sel = 2'b00; val2_sel = 2'b00; st_sel = 2'b00;
        exe_cmd = 4'd13; val1 = 32'd9;   val2 = 32'd0; run_iter("remu9_0");

        // Randomized iterative ops with forwarding
        for (int i = 0; i < 5; i++) begin
            randomize_inputs();
            exe_cmd = 4'(11 + $urandom_range(0, 2));
            if (i == 4) val2_sel = 2'b00;
            if (i == 4) val2 = 32'($urandom_range(1, 300));
            run_iter("iter_rand");
        end
        drain();

        // Backpressure on a SUB 3-5
        val1_sel = 2'b00; val2_sel = 2'b00; st_sel = 2'b00; br_type = 2'b00;
        exe_cmd = 4'd3; val1 = 32'd3; val2 = 32'd5;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        check("bp.out_valid", 32'(out_valid), 32'd1);
        check("bp.alu", out_alu, 32'hFFFF_FFFE);
        exe_cmd = 4'd2;
        for (int i = 0; i < 3; i++) begin
            check("bp.in_ready", 32'(in_ready), 32'd0);
            tick();
            check("bp.hold_alu", out_alu, 32'hFFFF_FFFE);
            check("bp.hold_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp.drop_valid", 32'(out_valid), 32'd0);

        // BNE with WB forwarding on the compare operand
        exe_cmd = 4'd0; val1 = 32'd1; val1_sel = 2'b00; st_sel = 2'b10; fwd_wb = 32'd1;
        br_type = 2'b10; pc_in = 32'h100; val2 = 32'h20; val2_sel = 2'b00;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bne.eq_taken", 32'(br_taken), 32'd0);
        tick();
        fwd_wb = 32'd2;
        #1;
        check("bne.ne_taken", 32'(br_taken), 32'd1);
        check("bne.addr", br_addr, 32'h120);
        tick();
        in_valid = 1'b0;
        #1;
        check("bne.no_valid", 32'(br_taken), 32'd0);
        br_type = 2'b00;
        drain();

        // Flush during ITER cycle 10 of a DIVU
        exe_cmd = 4'd12; val1 = 32'd1000; val2 = 32'd3; val1_sel = 2'b00; val2_sel = 2'b00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("flush.busy_before", 32'(busy), 32'd1);
        flush = 1'b1; in_valid = 1'b1; exe_cmd = 4'd2;
        #1;
        check("flush.in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush.busy", 32'(busy), 32'd0);
        check("flush.out_valid", 32'(out_valid), 32'd0);
        repeat (30) tick();
        check("flush.no_late_result", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a MUL
        exe_cmd = 4'd2; val1 = 32'd9; val2 = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        exe_cmd = 4'd11; val1 = 32'd7; val2 = 32'd6;
        tick();
        in_valid = 1'b0;
        check("rstmul.held_alu", out_alu, 32'd13);
        check("rstmul.busy", 32'(busy), 32'd1);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("rstmul.out_alu", out_alu, 32'd0);
        check("rstmul.out_valid", 32'(out_valid), 32'd0);
        check("rstmul.out_dest", 32'(out_dest), 32'd0);
        check("rstmul.busy_clr", 32'(busy), 32'd0);
        tick();
        #2 rst = 1'b0;
        tick();
        check("rstmul.in_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
